// File: rtl/i2s_pkg.sv
// i2s_pkg: shared widths and sample type for the I2S audio path.
// Used by the transmit side, the receive side and the CDC blocks.
package i2s_pkg;

  localparam int PKT_WIDTH_DEF = 16;
  localparam int FRAME_BITS    = 2 * PKT_WIDTH_DEF;

  typedef logic [PKT_WIDTH_DEF-1:0] pkt_t;

endpackage

// File: rtl/i2s_tx_sample_fifo.sv
// sample_fifo: small synchronous sample buffer.
// The head word is visible combinationally and is popped by the frame loader.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     popEn,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doWr;
  logic             doPop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign doWr  = wrEn & ~full;
  assign doPop = popEn & ~empty;
  assign head  = mem[rdPtr];

  // Pointers wrap naturally; occupancy moves by +1, -1 or 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr)  wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      unique case ({doWr, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono Philips-I2S transmitter in the bit-clock domain.
// Each sample is sent on both slots; the FIFO absorbs bursty writes.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH  = PKT_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clkI2SBit_i,
  input  logic                          rstI2S_i,
  input  logic [PKT_WIDTH-1:0]          pktTx_i,
  input  logic                          pktValidTx_i,
  output logic                          pktReadyTx_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
  output logic                          i2sWS_o,
  output logic                          i2sSD_o,
  output logic                          underrunTx_o,
  output logic                          overflowTx_o
);

  localparam int FRAME = 2 * PKT_WIDTH;
  localparam int KW    = $clog2(FRAME);
  localparam int IW    = $clog2(PKT_WIDTH);
  localparam logic [KW-1:0] K_LAST  = KW'(FRAME - 1);
  localparam logic [KW-1:0] K_RIGHT = KW'(PKT_WIDTH);

  logic [KW-1:0]        k;
  logic [KW-1:0]        kNext;
  logic [PKT_WIDTH-1:0] s;
  logic [PKT_WIDTH-1:0] sNext;
  logic [PKT_WIDTH-1:0] head;
  logic                 prevLsb;
  logic                 prevNext;
  logic                 lastBit;
  logic                 pop;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 wsNext;
  logic                 sdNext;
  logic                 undNext;

  sample_fifo #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clkI2SBit_i),
    .rst    (rstI2S_i),
    .wrEn   (pktValidTx_i),
    .wrData (pktTx_i),
    .popEn  (pop),
    .head   (head),
    .count  (fifoCount_o),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign pktReadyTx_o = ~fifoFull;
  assign overflowTx_o = pktValidTx_i & fifoFull & ~rstI2S_i;

  // Serial bit for slot position kk: one-bit delay after WS, MSB first.
  function automatic logic sdBit(
    input logic [KW-1:0]        kk,
    input logic [PKT_WIDTH-1:0] ss,
    input logic                 pl
  );
    logic          r;
    logic [IW-1:0] idx;
    idx = '0;
    r   = pl;
    if (kk == '0) begin
      r = pl;
    end else if (kk == K_RIGHT) begin
      r = ss[0];
    end else if (kk < K_RIGHT) begin
      idx = IW'(PKT_WIDTH - int'(kk));
      r   = ss[idx];
    end else begin
      idx = IW'(FRAME - int'(kk));
      r   = ss[idx];
    end
    return r;
  endfunction

  // State register: bit counter, held sample and registered outputs.
  always_ff @(posedge clkI2SBit_i) begin
    if (rstI2S_i) begin
      k            <= '0;
      s            <= '0;
      prevLsb      <= 1'b0;
      i2sWS_o      <= 1'b0;
      i2sSD_o      <= 1'b0;
      underrunTx_o <= 1'b0;
    end else begin
      k            <= kNext;
      s            <= sNext;
      prevLsb      <= prevNext;
      i2sWS_o      <= wsNext;
      i2sSD_o      <= sdNext;
      underrunTx_o <= undNext;
    end
  end

  // Next state: wrap the counter and load a frame on entry to k=0.
  always_comb begin
    lastBit  = (k == K_LAST);
    pop      = lastBit & ~fifoEmpty;
    kNext    = lastBit ? '0 : k + KW'(1);
    sNext    = pop ? head : s;
    prevNext = lastBit ? s[0] : prevLsb;
  end

  // Outputs for the coming bit position, registered above.
  always_comb begin
    wsNext  = (kNext >= K_RIGHT);
    sdNext  = sdBit(kNext, sNext, prevNext);
    undNext = lastBit & fifoEmpty;
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for the mono I2S transmitter.
// Accepted writes are queued; each captured frame pops its expectation.
module tb_i2s_tx;
  import i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  pkt_t       pkt;
  logic       vld;
  logic       rdy;
  logic [2:0] cnt;
  logic       ws;
  logic       sd;
  logic       und;
  logic       ovf;

  i2s_tx #(
    .PKT_WIDTH  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clkI2SBit_i  (clk),
    .rstI2S_i     (rst),
    .pktTx_i      (pkt),
    .pktValidTx_i (vld),
    .pktReadyTx_o (rdy),
    .fifoCount_o  (cnt),
    .i2sWS_o      (ws),
    .i2sSD_o      (sd),
    .underrunTx_o (und),
    .overflowTx_o (ovf)
  );

  int   checks = 0;
  int   errors = 0;
  int   kM     = 0;
  int   mCnt   = 0;
  pkt_t sbQ[$];
  pkt_t lastWord;
  bit   firstFrame;

  // Reference bit position and FIFO occupancy.
  always @(posedge clk) begin
    if (rst) begin
      kM   <= 0;
      mCnt <= 0;
    end else begin
      kM   <= (kM == 31) ? 0 : kM + 1;
      mCnt <= mCnt + ((vld && mCnt < 4) ? 1 : 0)
                   - ((kM == 31 && mCnt > 0) ? 1 : 0);
    end
  end

  task automatic waitK(input int t);
    int n;
    n = 0;
    while (kM != t && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (kM != t) begin
      checks++;
      errors++;
      $display("FAIL waitK got %0d need %0d", kM, t);
    end
  endtask

  task automatic writeWord(input pkt_t w);
    logic expOvf;
    checks++;
    if (rdy !== 1'(mCnt < 4)) begin
      errors++;
      $display("FAIL ready got %b need %b", rdy, mCnt < 4);
    end
    expOvf = 1'(mCnt == 4);
    vld = 1'b1;
    pkt = w;
    #1;
    checks++;
    if (ovf !== expOvf) begin
      errors++;
      $display("FAIL overflow got %b need %b", ovf, expOvf);
    end
    if (mCnt < 4) sbQ.push_back(w);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic capFrame(input string tag);
    pkt_t L;
    pkt_t R;
    pkt_t ex;
    logic u;
    logic expU;
    int   wsErr;
    waitK(0);
    u     = und;
    wsErr = (ws !== 1'b0) ? 1 : 0;
    L     = '0;
    R     = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      if (ws !== 1'(i >= 16)) wsErr++;
      if (i <= 16) L[16-i] = sd;
      else         R[32-i] = sd;
    end
    @(negedge clk);
    if (ws !== 1'b0) wsErr++;
    R[0] = sd;
    if (firstFrame) begin
      ex = '0;
      expU = 1'b0;
      firstFrame = 1'b0;
    end else if (sbQ.size() > 0) begin
      ex = sbQ.pop_front();
      expU = 1'b0;
    end else begin
      ex = lastWord;
      expU = 1'b1;
    end
    lastWord = ex;
    checks++;
    if (L !== ex) begin
      errors++;
      $display("FAIL %s left got %h need %h", tag, L, ex);
    end
    checks++;
    if (R !== ex) begin
      errors++;
      $display("FAIL %s right got %h need %h", tag, R, ex);
    end
    checks++;
    if (u !== expU) begin
      errors++;
      $display("FAIL %s underrun got %b need %b", tag, u, expU);
    end
    checks++;
    if (wsErr != 0) begin
      errors++;
      $display("FAIL %s ws got %0d bad bits need 0", tag, wsErr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 1'b0;
    pkt = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (ws !== 1'b0) begin
      errors++; $display("FAIL rst_ws got %b need 0", ws);
    end
    checks++;
    if (sd !== 1'b0) begin
      errors++; $display("FAIL rst_sd got %b need 0", sd);
    end
    checks++;
    if (cnt !== 3'd0) begin
      errors++; $display("FAIL rst_cnt got %0d need 0", cnt);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL rst_rdy got %b need 1", rdy);
    end
    checks++;
    if (und !== 1'b0) begin
      errors++; $display("FAIL rst_und got %b need 0", und);
    end
    vld = 1'b1;
    #1;
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got %b need 0", ovf);
    end
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b0;
    sbQ.delete();
    firstFrame = 1'b1;
    lastWord = '0;
  endtask

  task automatic test_idle();
    capFrame("idle1");
    capFrame("idle2");
    capFrame("idle3");
  endtask

  task automatic test_single();
    waitK(30);
    writeWord(16'hA5C3);
    checks++;
    if (cnt !== 3'(mCnt)) begin
      errors++; $display("FAIL single_cnt got %0d need %0d", cnt, mCnt);
    end
    capFrame("a5c3");
  endtask

  task automatic test_back_to_back();
    waitK(2);
    writeWord(16'hAAAA);
    writeWord(16'hBBBB);
    writeWord(16'hCCCC);
    writeWord(16'hDDDD);
    checks++;
    if (cnt !== 3'd4) begin
      errors++; $display("FAIL full_cnt got %0d need 4", cnt);
    end
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL full_rdy got %b need 0", rdy);
    end
    writeWord(16'h1234);
    checks++;
    if (cnt !== 3'd4) begin
      errors++; $display("FAIL ovf_cnt got %0d need 4", cnt);
    end
    capFrame("aaaa");
    capFrame("bbbb");
    capFrame("cccc");
    capFrame("dddd");
    capFrame("dddd_rep");
  endtask

  task automatic test_drain();
    writeWord(16'h5678);
    capFrame("5678");
    capFrame("5678_rep");
  endtask

  task automatic test_reset_mid();
    waitK(2);
    writeWord(16'h1111);
    writeWord(16'h2222);
    waitK(9);
    checks++;
    if (cnt !== 3'd2) begin
      errors++; $display("FAIL mid_pre_cnt got %0d need 2", cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ws !== 1'b0 || sd !== 1'b0) begin
      errors++; $display("FAIL mid_out got ws=%b sd=%b need 0 0", ws, sd);
    end
    checks++;
    if (cnt !== 3'd0 || rdy !== 1'b1) begin
      errors++; $display("FAIL mid_fifo got cnt=%0d rdy=%b need 0 1", cnt, rdy);
    end
    rst = 1'b0;
    sbQ.delete();
    firstFrame = 1'b1;
    lastWord = '0;
    capFrame("post_rst1");
    capFrame("post_rst2");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Mono I2S transmitter in the I2S bit-clock domain, the output end of the audio path. It accepts 16-bit signed DSP samples, buffers them in a small synchronous FIFO, and serialises each sample as a standard Philips-I2S stereo frame with the same word on left and right. The word-select and serial-data outputs go to the codec DAC. Fast-to-slow transfer from the DSP clock happens upstream; this block sees only the bit clock.

## Interface
- PKT_WIDTH, 16: sample width; also the slot width. The frame is 2*PKT_WIDTH bit clocks.
- FIFO_DEPTH, 4: sample buffer depth; power of two, at least 2.
- clkI2SBit_i  in  1: I2S bit clock, 1.4112 MHz; the single clock of the block.
- rstI2S_i  in  1: reset; synchronous, active-high.
- pktTx_i  in  PKT_WIDTH: sample to transmit, two's complement.
- pktValidTx_i  in  1: a sample is present on pktTx_i this cycle.
- pktReadyTx_o  out  1: FIFO can accept; equals (fifoCount_o < FIFO_DEPTH).
- fifoCount_o  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- i2sWS_o  out  1: word select; 0 = left slot, 1 = right slot.
- i2sSD_o  out  1: serial data, MSB first, one-bit I2S delay after WS.
- underrunTx_o  out  1: one-cycle pulse when a frame starts with the FIFO empty.
- overflowTx_o  out  1: one-cycle pulse when pktValidTx_i arrives while full; the sample is dropped.

## Operation
- Bit counter k runs 0 to 2*PKT_WIDTH-1 and wraps. It is the transmit state machine, and every output below is a registered function of k and the held sample S.
- i2sWS_o = 0 for k in 0..PKT_WIDTH-1; i2sWS_o = 1 for k in PKT_WIDTH..2*PKT_WIDTH-1.
- i2sSD_o, with PKT_WIDTH = 16:
  - k=0: bit 0 of the previous S (right-slot LSB).
  - k=1..15: S[16-k], so the left MSB is at k=1.
  - k=16: S[0].
  - k=17..31: S[32-k], so the right MSB is at k=17.
- Frame load happens on the edge entering k=0:
  - FIFO not empty: pop the head into S.
  - FIFO empty: keep S (repeat the last sample) and pulse underrunTx_o during k=0.
  - The previous S LSB is held separately so the k=0 bit stays correct.
- FIFO write: a transfer occurs on any cycle with pktValidTx_i & pktReadyTx_o.
- Write while full: overflowTx_o is high for that cycle and FIFO contents are unchanged.
- pktReadyTx_o depends only on count. A pop in the same cycle does not free a slot for a write at full.
- Simultaneous write and pop:
  - Count unchanged; the popped word is the old head.
  - If the FIFO is empty, the pop does not see the incoming word: underrun is flagged and the word is stored.
- Occupancy, pointers and wrap: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is updated +1, −1 or 0 per cycle.

## Timing
- Reset values, held every cycle rstI2S_i is high:
  - k=0, S=0, held LSB=0.
  - FIFO empty, fifoCount_o=0, pktReadyTx_o=1.
  - i2sWS_o=0, i2sSD_o=0, underrunTx_o=0, overflowTx_o=0.
- First frame after reset is all zeros. No underrun pulse on the first k=0 after reset.
- Reset mid-frame aborts the frame immediately and flushes the FIFO; the next frame starts from k=0 after release.
- Latency from write into an empty FIFO:
  - The write completes before the edge entering k=0, and its MSB appears on i2sSD_o at k=1.
  - Worst case is 2*PKT_WIDTH+1 cycles.
- Outputs change only on the rising edge. The top level forwards the bit clock inverted to the DAC, giving half a period of setup.
- Steady state: one pop every 2*PKT_WIDTH cycles, i.e. 44.1 kHz at the nominal clock.

## Structure
- Package i2s_pkg holds:
  - PKT_WIDTH default, FRAME_BITS = 2*PKT_WIDTH.
  - typedef pkt_t = logic [PKT_WIDTH-1:0], shared with the receive side and the CDC blocks.
- Sub-module sample_fifo: synchronous FIFO with write/pop, count, full and empty flags.
- Top-level logic (bit counter, sample register, output mux) stays in i2s_tx.

## Test plan
- Reset 10 cycles, no writes, 3 frames -> WS toggles every 16 cycles starting low; SD=0 throughout; underrunTx_o pulses at k=0 of frames 2 and 3.
- Write 16'hA5C3 before a frame boundary -> SD bits k=1..16 read A5C3 MSB-first; k=17..31 plus next-frame k=0 read A5C3 again; latency ≤33 cycles.
- Write AAAA, BBBB, CCCC, DDDD back-to-back -> fifoCount_o reaches 4, pktReadyTx_o=0; the four frames carry them in order with no underrun.
- Write a fifth word, 1234, while full -> overflowTx_o one pulse; 1234 is never transmitted.
- Let the FIFO drain after 5678 -> next frame repeats 5678 with an underrun pulse at its k=0.
- Assert rstI2S_i at k=9 with 2 words queued -> next cycle WS=0, SD=0, fifoCount_o=0; after release the first frame is all zeros.
